plab5_mcore_net_to_mem_req_buf: RTL and testbench
=================================================

Name: plab5_mcore_net_to_mem_req_buf

Overview:
- Bank-side ingress stage directly downstream of the core-side memory-request-to-network adapter, after the request network.
- Accepts split network messages: a low-security control word (header plus memory-request control fields plus domain bit) and a domain-labelled data word.
- Buffers them in a 2-entry queue, strips the network header, re-packs a full memory request for the cache/memory bank, and exposes the requester domain and source.

Parameters:
- p_num_ports, 4, number of cores/banks
- p_mem_opaque_nbits (mo), 8, memory opaque width
- p_mem_addr_nbits (ma), 32, memory address width
- p_mem_data_nbits (md), 32, memory data width
- p_net_opaque_nbits (no), 4, network opaque width
- p_net_srcdest_nbits (ns), 3, network src/dest width
- p_bank_domain, 0, domain this bank serves (used only with optional feature)
- Derived: mem control nbits mc = 3+mo+ma+clog2(md/8) = 45; net control nbits nc = mc+1+no+2*ns = 56; mem msg nbits = mc+md = 77

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_control  in  nc  {dest[ns], src[ns], opaque[no], domain[1], type[3], mopaque[mo], addr[ma], len[clog2(md/8)]}, MSB to LSB
- in_data  in  md  request data, labelled by the domain bit
- in_val  in  1  input valid
- in_rdy  out  1  input ready
- out_msg  out  mc+md  {type, mopaque, addr, len, data}
- out_domain  out  1  requester domain bit
- out_src  out  ns  requesting core id
- out_val  out  1  output valid
- out_rdy  in  1  output ready
- drop_count  out  8  dropped-request count (optional feature)

Behaviour:
- Reset (asynchronous, immediate): queue empty; out_val=0; in_rdy=1; out_msg, out_domain, out_src = 0; drop_count=0; head/tail pointers = 0.
- Storage: 2 entries, each holding control fields minus dest/net opaque, plus data. Control and data are kept in separate arrays. Data entries carry the entry's domain label.
- Enqueue when in_val && in_rdy. Dequeue when out_val && out_rdy.
- in_rdy = (count < 2). in_rdy does not depend on out_rdy; there is no bypass.
- Latency: an accepted message appears on out_* in the next cycle. out_* is driven from the head entry.
- Simultaneous enqueue and dequeue at count=1: count stays 1; the new entry follows the head.
- Pointers are 1 bit and wrap 1->0. count is 2 bits, range 0..2.
- Mem opaque is passed through unchanged; its high ns bits carry the source for response routing.
- Dest field is ignored. No check is made that dest equals this bank.
- out_msg, out_domain and out_src hold stable while out_val=1 and out_rdy=0.
- Reset asserted mid-transfer discards all entries; no partial message emerges after reset release.
- Data/domain fields are never combined into control-derived signals (in_rdy, out_val, pointers). This keeps control at level L.

Optional Feature:
- Macro: PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN.
- Defined:
  - Accepted messages with domain != p_bank_domain are consumed (in_rdy handshake completes) but not enqueued.
  - drop_count increments by 1 and saturates at 255.
  - A drop at count=2 cannot occur because in_rdy=0.
  - Drop and dequeue in the same cycle: only the dequeue affects count.
- Not defined: every accepted message is enqueued; drop_count is tied to 0; p_bank_domain is unused.

Test Plan:
- Reset then single request (src=1, domain=1, type=1 write, mopaque=0x25, addr=0x0000C010, len=0, data=0xDEADBEEF), out_rdy=1 -> next cycle out_val=1, out_msg={1,0x25,0x0000C010,0,0xDEADBEEF}, out_domain=1, out_src=1; following cycle out_val=0.
- out_rdy=0, send 3 back-to-back requests -> first two accepted, in_rdy=0 on the third until out_rdy=1; outputs arrive in order A, B, C.
- in_val=1 and out_rdy=1 held every cycle with 10 requests -> one accepted per cycle; out_val asserted continuously from cycle 2; count never exceeds 1.
- Assert reset while 2 entries are held -> out_val=0 immediately (asynchronous); after release, in_rdy=1 and no stale output appears.
- Macro defined, p_bank_domain=0: send domain=1, then domain=0 requests -> the first is dropped with drop_count=1; only the second appears on out_msg. Send 300 domain=1 requests -> drop_count=255.
- Macro undefined: same domain=1 request -> enqueued with out_domain=1; drop_count=0.

Source files
------------

// File: rtl/plab5_mcore_net_to_mem_req_buf.sv
// -----------------------------------------------------------------------------
// plab5_mcore_net_to_mem_req_buf
//
// This is the bank-side ingress buffer behind the request network. A network
// message arrives split into two words:
//   - a control word: {dest, src, net opaque, domain, type, mem opaque, addr, len}
//   - a data word, labelled with the requester's domain
// The buffer holds up to two messages. It drops the network header (dest and
// net opaque) and presents a full memory request to the bank. It also reports
// the requester's domain and source core.
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   in_control   network control word (nc bits, MSB first as listed above)
//   in_data      request data (md bits)
//   in_val/rdy   input handshake. in_rdy depends only on occupancy.
//   out_msg      {type, mem opaque, addr, len, data}
//   out_domain   requester domain bit
//   out_src      requesting core id
//   out_val/rdy  output handshake. The output is the head entry, so an
//                accepted message appears one cycle after it is taken.
//   drop_count   saturating count of requests dropped for a wrong domain
//
// Optional feature: PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN
//   When this macro is defined, a message whose domain differs from
//   p_bank_domain completes its input handshake but is discarded, and
//   drop_count records it. When the macro is undefined, every message is
//   buffered and drop_count is tied to zero.
// -----------------------------------------------------------------------------
module plab5_mcore_net_to_mem_req_buf #(
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_bank_domain       = 0,

  localparam int c_len_nbits = $clog2(p_mem_data_nbits / 8),
  localparam int c_mc_nbits  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + c_len_nbits,
  localparam int c_nc_nbits  = c_mc_nbits + 1 + p_net_opaque_nbits + 2 * p_net_srcdest_nbits,
  localparam int c_msg_nbits = c_mc_nbits + p_mem_data_nbits
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic [c_nc_nbits-1:0]          in_control,
  input  logic [p_mem_data_nbits-1:0]    in_data,
  input  logic                           in_val,
  output logic                           in_rdy,

  output logic [c_msg_nbits-1:0]         out_msg,
  output logic                           out_domain,
  output logic [p_net_srcdest_nbits-1:0] out_src,
  output logic                           out_val,
  input  logic                           out_rdy,

  output logic [7:0]                     drop_count
);

  // Bit offsets of the fields in in_control, counted from the LSB.
  localparam int c_dom_bit    = c_mc_nbits;
  localparam int c_nopq_lsb   = c_dom_bit + 1;
  localparam int c_src_lsb    = c_nopq_lsb + p_net_opaque_nbits;
  localparam int c_dest_lsb   = c_src_lsb + p_net_srcdest_nbits;

  // ---------------------------------------------------------------------------
  // Storage. Control fields and data are kept in separate arrays. The domain
  // label is stored with the data, not with the control fields.
  // ---------------------------------------------------------------------------
  logic [c_mc_nbits-1:0]          ctrl_q [2];
  logic [p_net_srcdest_nbits-1:0] src_q  [2];
  logic [p_mem_data_nbits:0]      data_q [2];   // {domain, data}

  logic       head_q, tail_q;
  logic [1:0] count_q;
  logic       head_d, tail_d;
  logic [1:0] count_d;

  logic accept, drop, enq, deq;

  // in_rdy and out_val come only from occupancy.
  assign in_rdy  = (count_q != 2'd2);
  assign out_val = (count_q != 2'd0);

  assign accept = in_val  && in_rdy;
  assign deq    = out_val && out_rdy;

`ifdef PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN
  // When this check is enabled, the domain bit decides whether the message is
  // stored. The handshake itself still depends only on occupancy.
  assign drop = accept && (in_control[c_dom_bit] != 1'(p_bank_domain));
`else
  assign drop = 1'b0;
`endif

  assign enq = accept && !drop;

  // ---------------------------------------------------------------------------
  // Next-state logic for the pointers and the occupancy count.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that leaves
    // a signal unassigned would infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = ~tail_q;
    if (deq) head_d = ~head_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;   // neither, or both at once
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every flop then samples values from before the clock edge, whatever the
  // order of the processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry arrays are not reset. The occupancy count says whether an
  // entry holds a message, and the outputs are forced to zero while the
  // buffer is empty. Stale contents can therefore never reach out_*.
  always_ff @(posedge clk) begin
    if (enq) begin
      ctrl_q[tail_q] <= in_control[c_mc_nbits-1:0];
      src_q[tail_q]  <= in_control[c_src_lsb +: p_net_srcdest_nbits];
      data_q[tail_q] <= {in_control[c_dom_bit], in_data};
    end
  end

  // ---------------------------------------------------------------------------
  // The outputs come from the head entry. The head pointer moves only on a
  // dequeue, so the outputs hold steady while out_rdy is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_msg    = '0;
    out_domain = 1'b0;
    out_src    = '0;
    if (out_val) begin
      out_msg    = {ctrl_q[head_q], data_q[head_q][p_mem_data_nbits-1:0]};
      out_domain = data_q[head_q][p_mem_data_nbits];
      out_src    = src_q[head_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Count of dropped requests. It saturates at 255.
  // ---------------------------------------------------------------------------
`ifdef PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (drop && (drop_count != 8'hff)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign drop_count = 8'd0;
`endif

  // The buffer ignores these header fields and configuration values. Bank
  // selection already happened in the network.
  logic unused_fields;
  assign unused_fields = ^{in_control[c_dest_lsb +: p_net_srcdest_nbits],
                           in_control[c_nopq_lsb +: p_net_opaque_nbits],
                           1'(p_num_ports), 1'(p_bank_domain)};

endmodule

// File: tb/tb_plab5_mcore_net_to_mem_req_buf.sv
// -----------------------------------------------------------------------------
// Testbench for plab5_mcore_net_to_mem_req_buf (default parameters).
// A queue model of the buffer is checked against the DUT on every falling
// edge. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_plab5_mcore_net_to_mem_req_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [55:0] in_control;
  logic [31:0] in_data;
  logic        in_val;
  logic        in_rdy;
  logic [76:0] out_msg;
  logic        out_domain;
  logic [2:0]  out_src;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  plab5_mcore_net_to_mem_req_buf dut (
    .clk        (clk),
    .reset      (reset),
    .in_control (in_control),
    .in_data    (in_data),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .out_msg    (out_msg),
    .out_domain (out_domain),
    .out_src    (out_src),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .drop_count (drop_count)
  );

`ifdef PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN
  localparam bit domain_check = 1'b1;
  localparam logic t1_dom = 1'b0;
`else
  localparam bit domain_check = 1'b0;
  localparam logic t1_dom = 1'b1;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model. This is a FIFO of at most two requests, plus the drop counter.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [76:0] msg;
    logic        dom;
    logic [2:0]  src;
  } item_t;

  item_t       m_q[$];
  int          m_drop;
  logic [31:0] seen[$];   // data words of dequeued messages, in order

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_drop = 0;
    end else begin
      bit acc, deq;
      item_t it;
      acc = in_val && (m_q.size() < 2);
      deq = out_rdy && (m_q.size() != 0);
      if (deq) void'(m_q.pop_front());
      if (acc) begin
        if (domain_check && in_control[45] != 1'b0) begin
          if (m_drop < 255) m_drop++;
        end else begin
          it.msg = {in_control[44:0], in_data};
          it.dom = in_control[45];
          it.src = in_control[52:50];
          m_q.push_back(it);
        end
      end
    end
  end

  // One comparison process runs on every falling edge.
  always @(negedge clk) begin
    check("in_rdy", 77'(in_rdy), 77'(m_q.size() < 2));
    check("out_val", 77'(out_val), 77'(m_q.size() != 0));
    check("drop_count", 77'(drop_count), 77'(m_drop));
    if (m_q.size() != 0) begin
      check("out_msg", out_msg, m_q[0].msg);
      check("out_domain", 77'(out_domain), 77'(m_q[0].dom));
      check("out_src", 77'(out_src), 77'(m_q[0].src));
    end
    if (out_val && out_rdy) seen.push_back(out_msg[31:0]);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [55:0] mk(input logic [2:0] dest, input logic [2:0] src,
                                     input logic dom, input logic [2:0] typ,
                                     input logic [7:0] mop, input logic [31:0] addr,
                                     input logic [1:0] len);
    return {dest, src, 4'hA, dom, typ, mop, addr, len};
  endfunction

  // Present a request, then wait until it is accepted (the wait is bounded).
  // in_val stays high on return. Callers lower it with idle_in().
  task automatic send(input logic [55:0] c, input logic [31:0] d, output int cyc);
    logic ok;
    in_control = c;
    in_data    = d;
    in_val     = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 50) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("accept_in_time", 77'(ok), 77'(1));
  endtask

  task automatic idle_in();
    in_val = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, tot;
    logic [31:0] exp_d[$];

    reset      = 1'b1;
    in_val     = 1'b0;
    in_control = '0;
    in_data    = '0;
    out_rdy    = 1'b0;

    // Reset state
    #12;
    check("rst_out_val", 77'(out_val), 77'(0));
    check("rst_in_rdy", 77'(in_rdy), 77'(1));
    check("rst_out_msg", out_msg, 77'(0));
    check("rst_out_src", 77'(out_src), 77'(0));
    check("rst_drop", 77'(drop_count), 77'(0));
    #10 reset = 1'b0;
    cycles(1);

    // Test 1: a single write request. It appears on the output one cycle
    // after it is accepted.
    out_rdy = 1'b1;
    send(mk(3'd0, 3'd1, t1_dom, 3'd1, 8'h25, 32'h0000C010, 2'd0), 32'hDEADBEEF, cyc);
    idle_in();
    @(negedge clk);
    check("t1_out_val", 77'(out_val), 77'(1));
    check("t1_out_msg", out_msg, {3'd1, 8'h25, 32'h0000C010, 2'd0, 32'hDEADBEEF});
    check("t1_out_domain", 77'(out_domain), 77'(t1_dom));
    check("t1_out_src", 77'(out_src), 77'(1));
    @(negedge clk);
    check("t1_out_val_after", 77'(out_val), 77'(0));
    cycles(1);

    // Test 2: back-pressure. A and B fill the buffer, and C waits until
    // out_rdy rises.
    seen.delete();
    out_rdy = 1'b0;
    send(mk(3'd2, 3'd2, 1'b0, 3'd0, 8'h41, 32'h00000100, 2'd3), 32'hAAAA0001, cyc);
    send(mk(3'd5, 3'd3, 1'b0, 3'd1, 8'h62, 32'h00000204, 2'd1), 32'hBBBB0002, cyc);
    in_control = mk(3'd7, 3'd4, 1'b0, 3'd0, 8'h83, 32'h00000308, 2'd2);
    in_data    = 32'hCCCC0003;
    in_val     = 1'b1;
    cycles(2);
    @(negedge clk);
    check("t2_full_in_rdy", 77'(in_rdy), 77'(0));
    check("t2_head_is_a", 77'(out_msg[31:0]), 77'(32'hAAAA0001));
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    send(in_control, in_data, cyc);
    idle_in();
    cycles(4);
    check("t2_count", 77'(seen.size()), 77'(3));
    if (seen.size() == 3) begin
      check("t2_order_a", 77'(seen[0]), 77'(32'hAAAA0001));
      check("t2_order_b", 77'(seen[1]), 77'(32'hBBBB0002));
      check("t2_order_c", 77'(seen[2]), 77'(32'hCCCC0003));
    end

    // Test 3: streaming. Ten requests go back to back, one per cycle.
    seen.delete();
    exp_d.delete();
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send(mk(3'(i), 3'(i), 1'b0, 3'(i), 8'(i * 17), 32'h1000 + 32'(i * 4), 2'(i)),
           32'h5000_0000 + 32'(i), cyc);
      tot += cyc;
      exp_d.push_back(32'h5000_0000 + 32'(i));
    end
    idle_in();
    cycles(3);
    check("t3_one_per_cycle", 77'(tot), 77'(10));
    check("t3_count", 77'(seen.size()), 77'(10));
    if (seen.size() == 10)
      for (int i = 0; i < 10; i++) check("t3_order", 77'(seen[i]), 77'(exp_d[i]));

    // Test 4: asynchronous reset while two entries are held.
    out_rdy = 1'b0;
    send(mk(3'd1, 3'd5, 1'b0, 3'd1, 8'hA5, 32'h0000ABC0, 2'd0), 32'h11111111, cyc);
    send(mk(3'd1, 3'd6, 1'b0, 3'd1, 8'hC6, 32'h0000ABC4, 2'd0), 32'h22222222, cyc);
    idle_in();
    #2;
    check("t4_full_before", 77'(out_val), 77'(1));
    reset = 1'b1;
    #1;
    check("t4_async_out_val", 77'(out_val), 77'(0));
    check("t4_async_out_msg", out_msg, 77'(0));
    cycles(1);
    #2 reset = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("t4_in_rdy_after", 77'(in_rdy), 77'(1));
    check("t4_no_stale", 77'(out_val), 77'(0));
    cycles(3);
    check("t4_no_stale_later", 77'(out_val), 77'(0));

    // Test 5: a domain=1 request, then a domain=0 request.
    seen.delete();
    send(mk(3'd0, 3'd2, 1'b1, 3'd1, 8'h47, 32'h0000D000, 2'd0), 32'h0D0D0001, cyc);
    send(mk(3'd0, 3'd3, 1'b0, 3'd1, 8'h68, 32'h0000D004, 2'd0), 32'h0D0D0000, cyc);
    idle_in();
    cycles(3);
`ifdef PLAB5_MCORE_NET_REQ_DOMAIN_CHECK_EN
    check("t5_drop_one", 77'(drop_count), 77'(1));
    check("t5_count", 77'(seen.size()), 77'(1));
    if (seen.size() == 1) check("t5_only_second", 77'(seen[0]), 77'(32'h0D0D0000));
    for (int i = 0; i < 300; i++)
      send(mk(3'd0, 3'd1, 1'b1, 3'd0, 8'h20, 32'(i), 2'd0), 32'(i), cyc);
    idle_in();
    cycles(2);
    check("t5_drop_saturate", 77'(drop_count), 77'(255));
`else
    check("t5_drop_zero", 77'(drop_count), 77'(0));
    check("t5_count", 77'(seen.size()), 77'(2));
    if (seen.size() == 2) begin
      check("t5_first_kept", 77'(seen[0]), 77'(32'h0D0D0001));
      check("t5_second", 77'(seen[1]), 77'(32'h0D0D0000));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
